// File: rtl/opb_register_bank_simulink2ppc_if.sv
// OPB slave-side bus bundle for the Simulink-to-PPC register bank.
// Vectors use OPB big-endian numbering: index 0 is the MSB, so bit [DWIDTH-1]
// of a data word is its numeric LSB.
//   slave  : bus inputs (ABus, BE, DBus, RNW, select, seqAddr), Sl_* outputs
//   master : the mirror image, for the bus side / testbench
interface opb_register_bank_simulink2ppc_if #(
    parameter int unsigned AWIDTH = 32,
    parameter int unsigned DWIDTH = 32
);
    logic [0:AWIDTH-1]   OPB_ABus;
    logic [0:DWIDTH/8-1] OPB_BE;
    logic [0:DWIDTH-1]   OPB_DBus;
    logic                OPB_RNW;
    logic                OPB_select;
    logic                OPB_seqAddr;
    logic [0:DWIDTH-1]   Sl_DBus;
    logic                Sl_xferAck;
    logic                Sl_errAck;
    logic                Sl_retry;
    logic                Sl_toutSup;

    modport slave (
        input  OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        output Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );

    modport master (
        output OPB_ABus, OPB_BE, OPB_DBus, OPB_RNW, OPB_select, OPB_seqAddr,
        input  Sl_DBus, Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup
    );
endinterface

// File: rtl/opb_register_bank_simulink2ppc.sv
// Multi-channel read-only register bank on OPB with a control/status word.
// Words 0..C_NUM_CH-1 are channels (live sample or event counter, chosen per
// bit of C_CNT_MASK); word C_NUM_CH is CTRL: bit0 FREEZE (r/w), bit1 CLEAR
// (write-1 pulse). FREEZE 0->1 (or 1->1) snapshots all channels into a shadow
// bank that reads return while FREEZE is set.
// Ports:
//   OPB_Clk, OPB_Rst_n : clock, async active-low reset
//   opb                : OPB slave bundle (address/data/control in, Sl_* out)
//   user_data_in       : packed live values, channel i at [i*W +: W]
//   user_event         : per-channel count enable, one count per high cycle
module opb_register_bank_simulink2ppc #(
    parameter logic [31:0] C_BASEADDR   = 32'h01040400,
    parameter logic [31:0] C_HIGHADDR   = 32'h010404FF,
    parameter int unsigned C_OPB_AWIDTH = 32,
    parameter int unsigned C_OPB_DWIDTH = 32,
    parameter int unsigned C_NUM_CH     = 4,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter logic [31:0] C_CNT_MASK   = 32'h0,
    parameter bit          C_CNT_SAT    = 1'b1
) (
    input  logic                             OPB_Clk,
    input  logic                             OPB_Rst_n,
    opb_register_bank_simulink2ppc_if.slave  opb,
    input  logic [C_NUM_CH*C_DATA_WIDTH-1:0] user_data_in,
    input  logic [C_NUM_CH-1:0]              user_event
);
    localparam int unsigned AW  = C_OPB_AWIDTH;
    localparam int unsigned DW  = C_OPB_DWIDTH;
    localparam int unsigned BW  = DW / 8;
    localparam int unsigned W   = C_DATA_WIDTH;
    localparam int unsigned NCH = C_NUM_CH;
    localparam int unsigned IW  = AW - 2;
    localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW-1:0] BASE = AW'(C_BASEADDR);
    localparam logic [AW-1:0] HIGH = AW'(C_HIGHADDR);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACK  = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_c, offset_c;
    logic [IW-1:0]   word_c;
    logic [CHW-1:0]  ch_sel_c;
    logic            hit_c, is_ch_c, is_ctrl_c, start_c;
    logic            wr_ctrl_c, capture_c, clear_c;
    logic [W-1:0]    chan_q   [NCH];
    logic [W-1:0]    shadow_q [NCH];
    logic            freeze_q;
    logic [DW-1:0]   rd_word_c, dbus_q;
    logic            unused_bits;

    // Address decode; big-endian bus vectors map positionally onto numeric values
    assign addr_c    = opb.OPB_ABus;
    assign offset_c  = addr_c - BASE;
    assign word_c    = offset_c[AW-1:2];
    assign ch_sel_c  = word_c[CHW-1:0];
    assign hit_c     = opb.OPB_select && (addr_c >= BASE) && (addr_c <= HIGH);
    assign is_ch_c   = word_c < IW'(NCH);
    assign is_ctrl_c = word_c == IW'(NCH);

    // Ack FSM next state; ACK always returns to IDLE so a held select acks every other cycle
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hit_c) begin
                    state_d = S_ACK;
                    start_c = 1'b1;
                end
            end
            S_ACK: state_d = S_IDLE;
        endcase
    end

    // Read mux; channel data zero-extended to the bus width
    always_comb begin
        rd_word_c = '0;
        if (is_ch_c) begin
            rd_word_c = DW'(freeze_q ? shadow_q[ch_sel_c] : chan_q[ch_sel_c]);
        end else if (is_ctrl_c) begin
            rd_word_c = DW'(freeze_q);
        end
    end

    // CTRL write strobes; OPB_DBus[DW-1] is numeric bit 0 (FREEZE)
    assign wr_ctrl_c = start_c && !opb.OPB_RNW && is_ctrl_c && opb.OPB_BE[BW-1];
    assign capture_c = wr_ctrl_c && opb.OPB_DBus[DW-1];
    assign clear_c   = wr_ctrl_c && opb.OPB_DBus[DW-2];

    // Ack state, FREEZE bit and read data register (zero outside the ack cycle)
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            state_q  <= S_IDLE;
            freeze_q <= 1'b0;
            dbus_q   <= '0;
        end else begin
            state_q <= state_d;
            if (wr_ctrl_c) begin
                freeze_q <= opb.OPB_DBus[DW-1];
            end
            dbus_q <= (start_c && opb.OPB_RNW) ? rd_word_c : '0;
        end
    end

    // Channel registers and snapshot bank; clear beats a same-cycle event
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                chan_q[i]   <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (C_CNT_MASK[i]) begin
                    if (clear_c) begin
                        chan_q[i] <= '0;
                    end else if (user_event[i]) begin
                        if (!(&chan_q[i])) begin
                            chan_q[i] <= chan_q[i] + W'(1);
                        end else if (!C_CNT_SAT) begin
                            chan_q[i] <= '0;
                        end
                    end
                end else begin
                    chan_q[i] <= user_data_in[i*W +: W];
                end
                if (capture_c) begin
                    shadow_q[i] <= chan_q[i];
                end
            end
        end
    end

    assign opb.Sl_DBus    = dbus_q;
    assign opb.Sl_xferAck = (state_q == S_ACK);
    assign opb.Sl_errAck  = 1'b0;
    assign opb.Sl_retry   = 1'b0;
    assign opb.Sl_toutSup = 1'b0;

    assign unused_bits = ^{opb.OPB_seqAddr, offset_c[1:0], opb.OPB_BE, opb.OPB_DBus};
endmodule

// File: tb/tb_opb_register_bank_simulink2ppc.sv
// Directed bench: dut_a is the default 4x32 bank with ch0/ch2 as counters,
// dut_b / dut_c are 4x4 banks with ch0 counting, saturating and wrapping.
module tb_opb_register_bank_simulink2ppc;
    localparam logic [31:0] BASE = 32'h01040400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  abus = '0;
    logic [3:0]   be = 4'hF;
    logic [31:0]  dbus = '0;
    logic         rnw = 1'b1;
    logic         sel = 1'b0;
    logic [1:0]   tgt = 2'd0;
    logic [127:0] ud_a = '0;
    logic [15:0]  ud_bc = '0;
    logic [3:0]   ev_a = '0;
    logic [3:0]   ev_bc = '0;
    logic         ack_m;
    logic [31:0]  dbus_m;
    logic         tied_m;
    int checks = 0;
    int errors = 0;

    opb_register_bank_simulink2ppc_if if_a ();
    opb_register_bank_simulink2ppc_if if_b ();
    opb_register_bank_simulink2ppc_if if_c ();

    assign if_a.OPB_ABus = abus;  assign if_b.OPB_ABus = abus;  assign if_c.OPB_ABus = abus;
    assign if_a.OPB_BE   = be;    assign if_b.OPB_BE   = be;    assign if_c.OPB_BE   = be;
    assign if_a.OPB_DBus = dbus;  assign if_b.OPB_DBus = dbus;  assign if_c.OPB_DBus = dbus;
    assign if_a.OPB_RNW  = rnw;   assign if_b.OPB_RNW  = rnw;   assign if_c.OPB_RNW  = rnw;
    assign if_a.OPB_seqAddr = 1'b0;
    assign if_b.OPB_seqAddr = 1'b0;
    assign if_c.OPB_seqAddr = 1'b0;
    assign if_a.OPB_select = sel && (tgt == 2'd0);
    assign if_b.OPB_select = sel && (tgt == 2'd1);
    assign if_c.OPB_select = sel && (tgt == 2'd2);

    opb_register_bank_simulink2ppc #(
        .C_CNT_MASK (32'h5)
    ) dut_a (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .opb          (if_a),
        .user_data_in (ud_a),
        .user_event   (ev_a)
    );

    opb_register_bank_simulink2ppc #(
        .C_DATA_WIDTH (4),
        .C_CNT_MASK   (32'h1),
        .C_CNT_SAT    (1'b1)
    ) dut_b (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .opb          (if_b),
        .user_data_in (ud_bc),
        .user_event   (ev_bc)
    );

    opb_register_bank_simulink2ppc #(
        .C_DATA_WIDTH (4),
        .C_CNT_MASK   (32'h1),
        .C_CNT_SAT    (1'b0)
    ) dut_c (
        .OPB_Clk      (clk),
        .OPB_Rst_n    (rst_n),
        .opb          (if_c),
        .user_data_in (ud_bc),
        .user_event   (ev_bc)
    );

    always_comb begin
        case (tgt)
            2'd0:    begin ack_m = if_a.Sl_xferAck; dbus_m = if_a.Sl_DBus; end
            2'd1:    begin ack_m = if_b.Sl_xferAck; dbus_m = if_b.Sl_DBus; end
            default: begin ack_m = if_c.Sl_xferAck; dbus_m = if_c.Sl_DBus; end
        endcase
        tied_m = if_a.Sl_errAck | if_a.Sl_retry | if_a.Sl_toutSup |
                 if_b.Sl_errAck | if_b.Sl_retry | if_b.Sl_toutSup |
                 if_c.Sl_errAck | if_c.Sl_retry | if_c.Sl_toutSup;
    end

    function automatic logic [31:0] waddr(input int k);
        return BASE + 32'(k * 4);
    endfunction

    // One transfer, starting and ending just after a falling edge:
    // ack1/data1 in the expected ack cycle, ack2/data2 one cycle later.
    task automatic bus_xfer(input logic [1:0] t, input logic [31:0] addr, input logic rnw_i,
                            input logic [31:0] wdata, input logic [3:0] be_i,
                            output logic ack1, output logic [31:0] data1,
                            output logic ack2, output logic [31:0] data2);
        tgt = t; abus = addr; rnw = rnw_i; dbus = wdata; be = be_i; sel = 1'b1;
        @(negedge clk);
        ack1 = ack_m; data1 = dbus_m;
        sel = 1'b0; rnw = 1'b1; dbus = '0; be = 4'hF;
        @(negedge clk);
        ack2 = ack_m; data2 = dbus_m;
    endtask

    task automatic pulse_ev_a(input int n);
        ev_a[0] = 1'b1;
        repeat (n) @(negedge clk);
        ev_a[0] = 1'b0;
    endtask

    task automatic pulse_ev_bc(input int n);
        ev_bc[0] = 1'b1;
        repeat (n) @(negedge clk);
        ev_bc[0] = 1'b0;
    endtask

    task automatic test_reset();
        logic a1, a2;
        logic [31:0] d1, d2;
        repeat (2) @(negedge clk);
        checks++;
        if (ack_m !== 1'b0 || dbus_m !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b dbus=%h, expected ack=0 dbus=0", ack_m, dbus_m);
        end
        checks++;
        if (tied_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_tied: got %b, expected 0", tied_m);
        end
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            bus_xfer(2'd0, waddr(k), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
            checks++;
            if (a1 !== 1'b1 || d1 !== 32'h0 || a2 !== 1'b0 || d2 !== 32'h0) begin
                errors++;
                $display("FAIL reset_read_ch%0d: ack=%b data=%h next_ack=%b next_data=%h, expected 1 0 0 0",
                         k, a1, d1, a2, d2);
            end
        end
    endtask

    task automatic test_live();
        logic a1, a2;
        logic [31:0] d1, d2;
        ud_a[32 +: 32] = 32'hDEADBEEF;
        ud_a[96 +: 32] = 32'h12345678;
        @(negedge clk);
        bus_xfer(2'd0, waddr(1), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'hDEADBEEF || a2 !== 1'b0 || d2 !== 32'h0) begin
            errors++;
            $display("FAIL live_ch1: ack=%b data=%h next_ack=%b next_data=%h, expected 1 deadbeef 0 0",
                     a1, d1, a2, d2);
        end
        bus_xfer(2'd0, waddr(3), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'h12345678) begin
            errors++;
            $display("FAIL live_ch3: ack=%b data=%h, expected 1 12345678", a1, d1);
        end
        // Channel words are read-only: write is acked, value unchanged
        bus_xfer(2'd0, waddr(1), 1'b0, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'h0) begin
            errors++;
            $display("FAIL ch_write_ack: ack=%b data=%h, expected 1 0", a1, d1);
        end
        bus_xfer(2'd0, waddr(1), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL ch_write_ignored: got %h, expected deadbeef", d1);
        end
    endtask

    task automatic test_counter_sat();
        logic a1, a2;
        logic [31:0] d1, d2;
        ud_bc[4 +: 4] = 4'hA;
        pulse_ev_bc(20);
        bus_xfer(2'd1, waddr(0), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'h0000000F) begin
            errors++;
            $display("FAIL cnt_saturate: ack=%b data=%h, expected 1 0000000f", a1, d1);
        end
        bus_xfer(2'd2, waddr(0), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'h00000004) begin
            errors++;
            $display("FAIL cnt_wrap: ack=%b data=%h, expected 1 00000004", a1, d1);
        end
        bus_xfer(2'd1, waddr(1), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'h0000000A) begin
            errors++;
            $display("FAIL narrow_live_zero_ext: got %h, expected 0000000a", d1);
        end
    endtask

    task automatic test_clear();
        logic a1, a2;
        logic [31:0] d1, d2;
        pulse_ev_a(7);
        bus_xfer(2'd0, waddr(0), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'd7) begin
            errors++;
            $display("FAIL cnt_seven: got %h, expected 00000007", d1);
        end
        bus_xfer(2'd0, waddr(2), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'd0) begin
            errors++;
            $display("FAIL idle_counter_ch2: got %h, expected 0", d1);
        end
        // CLEAR write with a same-cycle event
        ev_a[0] = 1'b1;
        tgt = 2'd0; abus = waddr(4); rnw = 1'b0; dbus = 32'h2; be = 4'hF; sel = 1'b1;
        @(negedge clk);
        ev_a[0] = 1'b0; sel = 1'b0; rnw = 1'b1; dbus = '0;
        @(negedge clk);
        bus_xfer(2'd0, waddr(0), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'd0) begin
            errors++;
            $display("FAIL clear_beats_event: got %h, expected 0", d1);
        end
        bus_xfer(2'd0, waddr(4), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'd0) begin
            errors++;
            $display("FAIL ctrl_after_clear: ack=%b data=%h, expected 1 0", a1, d1);
        end
        bus_xfer(2'd0, waddr(1), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL clear_spares_live: got %h, expected deadbeef", d1);
        end
        // CTRL write without BE[3] is ignored
        pulse_ev_a(3);
        bus_xfer(2'd0, waddr(4), 1'b0, 32'h2, 4'b1110, a1, d1, a2, d2);
        bus_xfer(2'd0, waddr(0), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'd3) begin
            errors++;
            $display("FAIL ctrl_be_gate: got %h, expected 00000003", d1);
        end
    endtask

    task automatic test_freeze();
        logic a1, a2;
        logic [31:0] d1, d2;
        bus_xfer(2'd0, waddr(4), 1'b0, 32'h1, 4'hF, a1, d1, a2, d2);
        ud_a[32 +: 32] = 32'h00000055;
        pulse_ev_a(3);
        bus_xfer(2'd0, waddr(1), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL frozen_live: got %h, expected deadbeef", d1);
        end
        bus_xfer(2'd0, waddr(0), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'd3) begin
            errors++;
            $display("FAIL frozen_counter: got %h, expected 00000003", d1);
        end
        bus_xfer(2'd0, waddr(4), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'h1) begin
            errors++;
            $display("FAIL ctrl_freeze_rb: got %h, expected 00000001", d1);
        end
        bus_xfer(2'd0, waddr(4), 1'b0, 32'h0, 4'hF, a1, d1, a2, d2);
        bus_xfer(2'd0, waddr(1), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'h55) begin
            errors++;
            $display("FAIL unfrozen_live: got %h, expected 00000055", d1);
        end
        bus_xfer(2'd0, waddr(0), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'd6) begin
            errors++;
            $display("FAIL unfrozen_counter: got %h, expected 00000006", d1);
        end
        // Writing FREEZE=1 while frozen re-captures
        bus_xfer(2'd0, waddr(4), 1'b0, 32'h1, 4'hF, a1, d1, a2, d2);
        ud_a[32 +: 32] = 32'h00000066;
        @(negedge clk);
        bus_xfer(2'd0, waddr(4), 1'b0, 32'h1, 4'hF, a1, d1, a2, d2);
        bus_xfer(2'd0, waddr(1), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'h66) begin
            errors++;
            $display("FAIL recapture: got %h, expected 00000066", d1);
        end
        bus_xfer(2'd0, waddr(4), 1'b0, 32'h0, 4'hF, a1, d1, a2, d2);
    endtask

    task automatic test_back_to_back();
        logic exp_ack;
        tgt = 2'd0; abus = waddr(0); rnw = 1'b1; sel = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            exp_ack = (c % 2 == 0);
            checks++;
            if (ack_m !== exp_ack || dbus_m !== (exp_ack ? 32'd6 : 32'd0)) begin
                errors++;
                $display("FAIL held_select_c%0d: ack=%b data=%h, expected ack=%b data=%h",
                         c, ack_m, dbus_m, exp_ack, exp_ack ? 32'd6 : 32'd0);
            end
        end
        sel = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_decode();
        logic a1, a2;
        logic [31:0] d1, d2;
        bus_xfer(2'd0, waddr(6), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'h0) begin
            errors++;
            $display("FAIL spare_word6: ack=%b data=%h, expected 1 0", a1, d1);
        end
        bus_xfer(2'd0, 32'h010404FC, 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'h0) begin
            errors++;
            $display("FAIL last_word: ack=%b data=%h, expected 1 0", a1, d1);
        end
        bus_xfer(2'd0, 32'h01040500, 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b0 || a2 !== 1'b0) begin
            errors++;
            $display("FAIL above_high: acks=%b%b, expected 00", a1, a2);
        end
        bus_xfer(2'd0, 32'h010403FC, 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b0 || a2 !== 1'b0) begin
            errors++;
            $display("FAIL below_base: acks=%b%b, expected 00", a1, a2);
        end
    endtask

    task automatic test_reset_mid();
        logic a1, a2;
        logic [31:0] d1, d2;
        bus_xfer(2'd0, waddr(4), 1'b0, 32'h1, 4'hF, a1, d1, a2, d2);
        tgt = 2'd0; abus = waddr(0); rnw = 1'b1; sel = 1'b1;
        @(negedge clk);
        checks++;
        if (ack_m !== 1'b1) begin
            errors++;
            $display("FAIL mid_ack_before: got %b, expected 1", ack_m);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (ack_m !== 1'b0 || dbus_m !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_abort: ack=%b data=%h, expected 0 0", ack_m, dbus_m);
        end
        @(negedge clk);
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_xfer(2'd0, waddr(4), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (a1 !== 1'b1 || d1 !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_ctrl: ack=%b data=%h, expected 1 0", a1, d1);
        end
        bus_xfer(2'd0, waddr(0), 1'b1, 32'h0, 4'hF, a1, d1, a2, d2);
        checks++;
        if (d1 !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_counter: got %h, expected 0", d1);
        end
        checks++;
        if (tied_m !== 1'b0) begin
            errors++;
            $display("FAIL tied_end: got %b, expected 0", tied_m);
        end
    endtask

    initial begin
        test_reset();
        test_live();
        test_counter_sat();
        test_clear();
        test_freeze();
        test_back_to_back();
        test_decode();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
